debouncer_multi: RTL

Parametrised multi-channel switch debouncer: N_CH independent asynchronous switch inputs are synchronised, filtered by a per-channel stability counter and presented as clean levels plus single-cycle rise/fall event pulses. A shared prescaler sets the sampling rate, so one instance covers any button bank from fast-clock to slow-clock domains. It sits between board-level pushbuttons/switches and the control logic or interrupt aggregator.

---
 rtl/debouncer_pkg.sv | 18 +
 rtl/debouncer_ch.sv | 86 ++++++++
 rtl/debouncer_multi.sv | 85 ++++++++
 3 files changed

// File: rtl/debouncer_pkg.sv
// rtl/debouncer_pkg.sv - shared constants and helpers for the switch debouncer
//
// Purpose: default parameter values and the counter-width helper that the
//          channel and the top-level wrapper both rely on.
// Ports:   none (package)
package debouncer_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_STABLE_CNT  = 10;
    localparam int DEF_PRESCALE    = 1;

    // Width of a counter that must represent values 0..stable_cnt.
    function automatic int cnt_w(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/debouncer_ch.sv
// rtl/debouncer_ch.sv - one debounced switch channel
//
// Purpose: synchronises one asynchronous switch, filters it with a stability
//          counter advanced on sampling ticks and registers clean level and
//          single-cycle edge pulses.
// Ports:   clk_i   - system clock
//          rst_i   - asynchronous active-low reset
//          tick_i  - sampling tick from the shared prescaler
//          sw_i    - raw switch input, asynchronous to clk_i
//          db_o    - debounced level
//          rise_o  - one-cycle pulse on an accepted 0->1
//          fall_o  - one-cycle pulse on an accepted 1->0
//          busy_o  - synchronised level differs from db_o
module debouncer_ch
    import debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   STABLE_CNT  = DEF_STABLE_CNT,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CW = cnt_w(STABLE_CNT);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_i};
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s == db_q) begin
            // Bounce back to the accepted level clears the count at once,
            // regardless of the sampling tick.
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CW'(STABLE_CNT - 1)) begin
                db_d   = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            cnt_q  <= '0;
            db_q   <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    // Both operands are flops, so busy_o carries no input-to-output path.
    assign busy_o = (s != db_q);

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel switch debouncer with shared prescaler
//
// Purpose: N_CH independent debounced channels sampled on a common tick,
//          plus an interrupt line built from the masked edge pulses.
// Ports:   clk_i   - system clock
//          rst_i   - asynchronous active-low reset
//          sw_i    - raw switch inputs [N_CH]
//          db_o    - debounced levels [N_CH]
//          rise_o  - accepted 0->1 pulses [N_CH]
//          fall_o  - accepted 1->0 pulses [N_CH]
//          busy_o  - channel filter running [N_CH]
//          irq_o   - OR of masked rise/fall pulses
module debouncer_multi
    import debouncer_pkg::*;
#(
    parameter int              N_CH        = DEF_N_CH,
    parameter int              SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int              STABLE_CNT  = DEF_STABLE_CNT,
    parameter int              PRESCALE    = DEF_PRESCALE,
    parameter logic            RST_VAL     = 1'b0,
    parameter logic [N_CH-1:0] EV_MASK     = '1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] sw_i,
    output logic [N_CH-1:0] db_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] busy_o,
    output logic            irq_o
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("debouncer_multi: N_CH must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debouncer_multi: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CNT < 1) begin : g_bad_stable
        $error("debouncer_multi: STABLE_CNT must be at least 1");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("debouncer_multi: PRESCALE must be at least 1");
    end

    // With PRESCALE == 1 the single prescaler bit stays 0 and every cycle ticks.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debouncer_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_CNT  (STABLE_CNT),
            .RST_VAL     (RST_VAL)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .tick_i (tick),
            .sw_i   (sw_i[i]),
            .db_o   (db_o[i]),
            .rise_o (rise_o[i]),
            .fall_o (fall_o[i]),
            .busy_o (busy_o[i])
        );
    end

    assign irq_o = |((rise_o | fall_o) & EV_MASK);

endmodule
